// File: rtl/add_rr_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared-adder arbiter and the response consumer.
interface add_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 64
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_chain;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter sharing one carry-select adder among NREQ requesters, with per-requester carry chaining.
// Define ADD_ARB_SUB_EN to enable subtraction via req_sub (operand B inverted, carry-in forced to 1).
module add_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 64
) (
  input logic              clk,
  input logic              rst,
  add_rr_arbiter_if.slave  bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int LO_W = W / 2;
  localparam int HI_W = W - LO_W;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d;
  logic [W-1:0]      rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic [NREQ-1:0]   carry_q, carry_d;

  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    cand;
  logic              grant_found;
  logic [NREQ-1:0]   ready;
  logic [W-1:0]      op_b;
  logic              op_cin;
  logic [W:0]        sum_full;

  // Upper half is precomputed for both carry-ins and picked by the lower half's carry-out.
  function automatic logic [W:0] csel_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    logic [LO_W:0] lo;
    logic [HI_W:0] hi0, hi1;
    lo  = {1'b0, x[LO_W-1:0]} + {1'b0, y[LO_W-1:0]} + (LO_W+1)'(c);
    hi0 = {1'b0, x[W-1:LO_W]} + {1'b0, y[W-1:LO_W]};
    hi1 = {1'b0, x[W-1:LO_W]} + {1'b0, y[W-1:LO_W]} + (HI_W+1)'(1);
    return lo[LO_W] ? {hi1, lo[LO_W-1:0]} : {hi0, lo[LO_W-1:0]};
  endfunction

  // Search starts one past the last winner so the most recent winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last_grant_q) + off) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == IDLE && grant_found && !rst) ready[grant_idx] = 1'b1;
  end

  always_comb begin
    op_b   = bus.req_b[grant_idx*W +: W];
    op_cin = bus.req_chain[grant_idx] ? carry_q[grant_idx] : bus.req_cin[grant_idx];
`ifdef ADD_ARB_SUB_EN
    if (bus.req_sub[grant_idx]) begin
      op_b = ~op_b;
      if (!bus.req_chain[grant_idx]) op_cin = 1'b1;
    end
`endif
  end

`ifndef ADD_ARB_SUB_EN
  logic unused_sub;
  assign unused_sub = &{1'b0, bus.req_sub};
`endif

  assign sum_full = csel_add(a_q, b_q, cin_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;
    carry_d      = carry_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d          = bus.req_a[grant_idx*W +: W];
          b_d          = op_b;
          cin_d        = op_cin;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d     = sum_full[W-1:0];
        rsp_cout_d    = sum_full[W];
        rsp_id_d      = id_q;
        carry_d[id_q] = sum_full[W];
        state_d       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      carry_q      <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      carry_q      <= carry_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Operand registers are only meaningful after a grant, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
    id_q  <= id_d;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule
